pmem_arbiter: RTL and testbench



---
 rtl/pmem_arb_pkg.sv | 13 +
 rtl/pmem_arb_select.sv | 20 ++
 rtl/pmem_arbiter.sv | 135 +++++++++++++
 tb/tb_pmem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the icache/dcache physical-memory arbiter.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  localparam int PMEM_ADDR_W = 32;
  localparam int PMEM_LINE_W = 256;

endpackage

// File: rtl/pmem_arb_select.sv
// Combinational grant picker: dcache wins unless the icache has waited through STARVE_MAX dcache grants.
module pmem_arb_select #(
  parameter int STARVE_MAX = 4,
  parameter int STREAK_W   = $clog2(STARVE_MAX + 1)
) (
  input  logic                dreq_i,
  input  logic                ireq_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_i_o,
  output logic                grant_d_o
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

  always_comb begin
    grant_d_o = dreq_i && (!ireq_i || (streak_i < STREAK_LIMIT));
    grant_i_o = ireq_i && !grant_d_o;
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one cacheline adapter between icache and dcache; one whole-line transaction at a time,
// dcache-priority with a bounded starvation streak for the icache.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W     = PMEM_ADDR_W,
  parameter int LINE_W     = PMEM_LINE_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                op_write_q, op_write_d;
  logic                dreq, grant_i, grant_d;

  assign dreq = d_pmem_read | d_pmem_write;

  pmem_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .STREAK_W   (STREAK_W)
  ) u_select (
    .dreq_i    (dreq),
    .ireq_i    (i_pmem_read),
    .streak_i  (streak_q),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    op_write_d  = op_write_q;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = BUSY_D;
          addr_d     = d_pmem_address;
          wdata_d    = d_pmem_wdata;
          // A simultaneous read+write from the dcache is treated as the writeback.
          op_write_d = d_pmem_write;
          rd_d       = !d_pmem_write;
          if (!i_pmem_read) begin
            streak_d = '0;
          end else if (streak_q != STREAK_LIMIT) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_i) begin
          state_d    = BUSY_I;
          addr_d     = i_pmem_address;
          op_write_d = 1'b0;
          rd_d       = 1'b1;
          streak_d   = '0;
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          i_pmem_resp = 1'b1;
          state_d     = IDLE;
          rd_d        = 1'b0;
          op_write_d  = 1'b0;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          d_pmem_resp = 1'b1;
          state_d     = IDLE;
          rd_d        = 1'b0;
          op_write_d  = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        rd_d       = 1'b0;
        op_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      op_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      op_write_q <= op_write_d;
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = op_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  // Read data is broadcast; only the resp pulse tells a cache the line is its own.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: vector table, directed corner sequences, random traffic vs. model.
module tb_pmem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam logic [255:0] LINE_A5   = {32{8'hA5}};
  localparam logic [255:0] LINE_5A   = {32{8'h5A}};
  localparam logic [255:0] LINE_DEAD = {8{32'hDEADBEEF}};
  localparam logic [255:0] LINE_CNT  = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;

  logic         clk, rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata, d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  pmem_arbiter #(
    .ADDR_W     (32),
    .LINE_W     (256),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Entered at a slot just after a rising edge. Waits for a command, lets the adapter answer
  // in the lat-th busy cycle counted from the first one seen here, and checks the resp routing.
  task automatic run_txn(input int lat, input logic [255:0] rd, input bit exp_d,
                         output logic [31:0] addr, output bit wr);
    int w;
    w = 0;
    while (!(pmem_read || pmem_write) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("txn_timeout", (w >= 20), 1'b0);
    addr = pmem_address;
    wr   = pmem_write;
    if (w >= 20) return;
    repeat (lat - 1) begin
      @(negedge clk);
      chk("txn_early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
      @(posedge clk); #1;
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    @(negedge clk);
    chk("txn_i_resp", i_pmem_resp, !exp_d);
    chk("txn_d_resp", d_pmem_resp, exp_d);
    chk("txn_rdata", exp_d ? d_pmem_rdata : i_pmem_rdata, rd);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  typedef struct {
    bit           i_rd;
    bit           d_rd;
    bit           d_wr;
    logic [31:0]  ia;
    logic [31:0]  da;
    logic [255:0] wd;
    int           lat;
    logic [255:0] rd;
    bit           exp_d;
    bit           exp_wr;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t         vecs [6];
  logic [31:0]  got_addr;
  bit           got_wr;

  // Reference model state for the random phase.
  int           m_busy;     // 0 idle, 1 icache, 2 dcache
  int           m_streak;
  logic [31:0]  m_addr;
  bit           m_wr;
  logic [255:0] m_wdata;
  int           alat;
  int           dop;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 256'h0,    5, LINE_A5, 1'b0, 1'b0, 32'h0000_1000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 256'h0, 3, LINE_5A, 1'b1, 1'b0, 32'h0000_0200};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 256'h0,    2, LINE_CNT, 1'b0, 1'b0, 32'h0000_0100};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0300, LINE_DEAD, 4, LINE_A5, 1'b1, 1'b1, 32'h0000_0300};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0340, LINE_CNT,  2, LINE_5A, 1'b1, 1'b1, 32'h0000_0340};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0400, 256'h0,    3, LINE_DEAD, 1'b1, 1'b0, 32'h0000_0400};

    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmds", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 32'h0);
    chk("rst_wdata", pmem_wdata, 256'h0);
    chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table: one isolated transaction per row.
    for (int v = 0; v < 6; v++) begin
      i_pmem_read    = vecs[v].i_rd;
      i_pmem_address = vecs[v].ia;
      d_pmem_read    = vecs[v].d_rd;
      d_pmem_write   = vecs[v].d_wr;
      d_pmem_address = vecs[v].da;
      d_pmem_wdata   = vecs[v].wd;
      @(negedge clk);
      chk("tbl_no_cmd_yet", {pmem_read, pmem_write}, 2'b00);
      @(negedge clk);
      chk("tbl_read", pmem_read, !vecs[v].exp_wr);
      chk("tbl_write", pmem_write, vecs[v].exp_wr);
      chk("tbl_addr", pmem_address, vecs[v].exp_addr);
      if (vecs[v].exp_wr) chk("tbl_wdata", pmem_wdata, vecs[v].wd);
      i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      @(posedge clk); #1;
      run_txn(vecs[v].lat - 1, vecs[v].rd, vecs[v].exp_d, got_addr, got_wr);
      chk("tbl_txn_addr", got_addr, vecs[v].exp_addr);
    end

    // Writeback then read of the same line, read raised in the resp cycle.
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0300; d_pmem_wdata = LINE_DEAD;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_write", {pmem_read, pmem_write}, 2'b01);
    chk("wb_wdata", pmem_wdata, LINE_DEAD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = LINE_5A;
    d_pmem_write = 1'b0; d_pmem_read = 1'b1;
    @(negedge clk);
    chk("wb_d_resp", d_pmem_resp, 1'b1);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("wb_turnaround_idle", {pmem_read, pmem_write}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_then_read", {pmem_read, pmem_write}, 2'b10);
    chk("wb_read_addr", pmem_address, 32'h0000_0300);
    d_pmem_read = 1'b0;
    @(posedge clk); #1;
    run_txn(2, LINE_A5, 1'b1, got_addr, got_wr);

    // Starvation: both held high continuously; expect four D grants then one I, twice.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      run_txn(2, rand_line(), ((k % 5) != 4), got_addr, got_wr);
      chk("starve_addr", got_addr, ((k % 5) != 4) ? 32'h0000_0200 : 32'h0000_0100);
      chk("starve_op", got_wr, 1'b0);
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;

    // Dcache drops its request after two cycles of a six-cycle transfer.
    @(posedge clk); #1;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_pmem_read = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("drop_read_held", pmem_read, 1'b1);
      chk("drop_no_resp", d_pmem_resp, 1'b0);
      @(posedge clk); #1;
    end
    pmem_resp = 1'b1; pmem_rdata = LINE_CNT;
    @(negedge clk);
    chk("drop_d_resp", d_pmem_resp, 1'b1);
    chk("drop_d_rdata", d_pmem_rdata, LINE_CNT);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("drop_done", {pmem_read, d_pmem_resp}, 2'b00);

    // Stray adapter resp while idle is ignored.
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("stray_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("stray_cmds", {pmem_read, pmem_write}, 2'b00);

    // Reset in the third busy cycle of a dcache read.
    @(posedge clk); #1;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; d_pmem_read = 1'b0;
    @(negedge clk);
    chk("rstmid_cmd_before", pmem_read, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_cmds", {pmem_read, pmem_write}, 2'b00);
    chk("rstmid_addr", pmem_address, 32'h0);
    chk("rstmid_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);

    // Random traffic against the transaction-level model.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_streak = 0; m_addr = '0; m_wr = 1'b0; m_wdata = '0; alat = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (m_busy == 0) begin
        if ((d_pmem_read || d_pmem_write) && (!i_pmem_read || m_streak < STARVE_MAX)) begin
          m_busy   = 2;
          m_addr   = d_pmem_address;
          m_wr     = d_pmem_write;
          m_wdata  = d_pmem_wdata;
          m_streak = i_pmem_read ? ((m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1) : 0;
        end else if (i_pmem_read) begin
          m_busy   = 1;
          m_addr   = i_pmem_address;
          m_wr     = 1'b0;
          m_streak = 0;
        end
      end else if (pmem_resp) begin
        m_busy = 0;
      end

      if (i_pmem_read) begin
        if ($urandom_range(0, 7) == 0) i_pmem_read = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_pmem_read = 1'b1;
      end
      if (d_pmem_read || d_pmem_write) begin
        if ($urandom_range(0, 7) == 0) begin
          d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dop = $urandom_range(0, 2);
        d_pmem_read  = (dop != 1);
        d_pmem_write = (dop != 0);
      end
      i_pmem_address = $urandom;
      d_pmem_address = $urandom;
      d_pmem_wdata   = rand_line();
      pmem_rdata     = rand_line();

      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (alat < 0) alat = $urandom_range(0, 5);
        if (alat == 0) begin
          pmem_resp = 1'b1;
          alat = -1;
        end else begin
          alat--;
        end
      end else begin
        alat = -1;
        if ($urandom_range(0, 15) == 0) pmem_resp = 1'b1;
      end

      @(negedge clk);
      chk("rnd_read", pmem_read, (m_busy != 0) && !m_wr);
      chk("rnd_write", pmem_write, (m_busy != 0) && m_wr);
      chk("rnd_addr", pmem_address, m_addr);
      if (m_busy == 2 && m_wr) chk("rnd_wdata", pmem_wdata, m_wdata);
      chk("rnd_i_resp", i_pmem_resp, (m_busy == 1) && pmem_resp);
      chk("rnd_d_resp", d_pmem_resp, (m_busy == 2) && pmem_resp);
      chk("rnd_i_rdata", i_pmem_rdata, pmem_rdata);
      chk("rnd_d_rdata", d_pmem_rdata, pmem_rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
